mem_port_arbiter: RTL and testbench

//  Shares one single-ported synchronous memory between instruction fetch (IF) and load/store (D).

---
 rtl/mem_port_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported synchronous memory between instruction fetch and load/store.
// One transaction in flight, fixed read latency, data priority with a fetch starvation limit.
module mem_port_arbiter #(
  parameter int LAT        = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_kill,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam logic [2:0] LAT_C    = 3'(LAT);
  localparam logic [2:0] STARVE_C = 3'(STARVE_MAX);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state_r, state_nxt_s;
  logic [2:0] cnt_r, cnt_nxt_s;
  logic [2:0] starve_r, starve_nxt_s;
  logic       owner_d_r, owner_nxt_s;
  logic       kill_r, kill_nxt_s;

  logic done_s, free_s, if_elig_s, if_gnt_s, d_gnt_s, any_gnt_s;

  // Arbitration: port is free when idle or on the response cycle of the current access
  always_comb begin
    done_s    = (state_r == BUSY) && (cnt_r == LAT_C);
    free_s    = (state_r == IDLE) || done_s;
    if_elig_s = if_req && !if_kill;
    if_gnt_s  = 1'b0;
    d_gnt_s   = 1'b0;
    if (reset) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (free_s) begin
      if (if_elig_s && (!d_req || (starve_r == STARVE_C))) begin
        if_gnt_s = 1'b1;
      end else if (d_req) begin
        d_gnt_s = 1'b1;
      end else begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
      end
    end else begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end
    any_gnt_s = if_gnt_s || d_gnt_s;
  end

  // Next-state: latency counter, owner tracking and the fetch kill flag
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    owner_nxt_s = owner_d_r;
    case (state_r)
      IDLE: begin
        if (any_gnt_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = 3'd1;
          owner_nxt_s = d_gnt_s;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end
      end
      BUSY: begin
        if (!done_s) begin
          cnt_nxt_s = cnt_r + 3'd1;
        end else if (any_gnt_s) begin
          state_nxt_s = BUSY;
          cnt_nxt_s   = 3'd1;
          owner_nxt_s = d_gnt_s;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 3'd0;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 3'd0;
        owner_nxt_s = 1'b0;
      end
    endcase

    // A kill during an outstanding fetch hides its response; the flag lives until completion
    if (done_s) begin
      kill_nxt_s = 1'b0;
    end else if ((state_r == BUSY) && !owner_d_r && if_kill) begin
      kill_nxt_s = 1'b1;
    end else begin
      kill_nxt_s = kill_r;
    end

    if (if_gnt_s || !if_req) begin
      starve_nxt_s = 3'd0;
    end else if (d_gnt_s && if_req && !if_kill && (starve_r < STARVE_C)) begin
      starve_nxt_s = starve_r + 3'd1;
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= 3'd0;
      starve_r  <= 3'd0;
      owner_d_r <= 1'b0;
      kill_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      starve_r  <= starve_nxt_s;
      owner_d_r <= owner_nxt_s;
      kill_r    <= kill_nxt_s;
    end
  end

  assign if_gnt    = if_gnt_s;
  assign d_gnt     = d_gnt_s;
  assign if_rvalid = done_s && !owner_d_r && !kill_r && !if_kill && !reset;
  assign d_rvalid  = done_s && owner_d_r && !reset;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

  // Memory request follows the winner in the grant cycle; address parks on the fetch address
  assign mem_en    = any_gnt_s;
  assign mem_we    = d_we && d_gnt_s;
  assign mem_be    = d_gnt_s ? d_be : 4'b0000;
  assign mem_wdata = d_wdata;
  assign mem_addr  = d_gnt_s ? d_addr : if_addr;

  assign busy = (state_r == BUSY) && !(done_s && !any_gnt_s) && !reset;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LAT=1,2,3) driven in lockstep,
// each scenario checks only the instance whose latency it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, if_kill, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic        if_gnt_w [3];
  logic        if_rvalid_w [3];
  logic [31:0] if_rdata_w [3];
  logic        d_gnt_w [3];
  logic        d_rvalid_w [3];
  logic [31:0] d_rdata_w [3];
  logic        mem_en_w [3];
  logic        mem_we_w [3];
  logic [31:0] mem_addr_w [3];
  logic [31:0] mem_wdata_w [3];
  logic [3:0]  mem_be_w [3];
  logic        busy_w [3];

  int checks = 0;
  int failures = 0;
  logic [7:0] d_order;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_port_arbiter #(.LAT(g + 1), .STARVE_MAX(3)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_gnt(if_gnt_w[g]), .if_rvalid(if_rvalid_w[g]), .if_rdata(if_rdata_w[g]),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_gnt(d_gnt_w[g]), .d_rvalid(d_rvalid_w[g]), .d_rdata(d_rdata_w[g]),
      .mem_en(mem_en_w[g]), .mem_we(mem_we_w[g]), .mem_addr(mem_addr_w[g]),
      .mem_wdata(mem_wdata_w[g]), .mem_be(mem_be_w[g]), .mem_rdata(mem_rdata),
      .busy(busy_w[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    if_req  = 1'b0;
    if_kill = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    if_addr = 32'h0000_0100;
    d_addr  = 32'h0000_0040;
    d_wdata = 32'h0000_0000;
    d_be    = 4'b0000;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    mem_rdata = 32'h0000_DEAD;
    do_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", {31'd0, busy_w[i]}, 32'd0);
      chk("rst_mem_en", {31'd0, mem_en_w[i]}, 32'd0);
      chk("rst_mem_be", {28'd0, mem_be_w[i]}, 32'd0);
      chk("rst_rvalid", {30'd0, if_rvalid_w[i], d_rvalid_w[i]}, 32'd0);
    end

    // Scenario 1: LAT=1 fetch stream
    do_reset();
    if_req = 1'b1;
    #1;
    chk("t1_if_gnt_T", {31'd0, if_gnt_w[0]}, 32'd1);
    chk("t1_mem_addr", mem_addr_w[0], 32'h0000_0100);
    chk("t1_mem_en", {31'd0, mem_en_w[0]}, 32'd1);
    chk("t1_rvalid_T", {31'd0, if_rvalid_w[0]}, 32'd0);
    cyc(); #1;
    chk("t1_rvalid_T1", {31'd0, if_rvalid_w[0]}, 32'd1);
    chk("t1_rdata", if_rdata_w[0], 32'h0000_DEAD);
    chk("t1_gnt_b2b", {31'd0, if_gnt_w[0]}, 32'd1);
    chk("t1_busy_b2b", {31'd0, busy_w[0]}, 32'd1);
    cyc(); if_req = 1'b0; #1;
    chk("t1_rvalid_T2", {31'd0, if_rvalid_w[0]}, 32'd1);
    chk("t1_busy_end", {31'd0, busy_w[0]}, 32'd0);
    cyc(); #1;
    chk("t1_rvalid_T3", {31'd0, if_rvalid_w[0]}, 32'd0);

    // Scenario 2: LAT=2, simultaneous requests, data first
    do_reset();
    if_req = 1'b1; d_req = 1'b1; d_addr = 32'h0000_0040;
    #1;
    chk("t2_d_gnt_T", {31'd0, d_gnt_w[1]}, 32'd1);
    chk("t2_if_gnt_T", {31'd0, if_gnt_w[1]}, 32'd0);
    chk("t2_mem_addr_T", mem_addr_w[1], 32'h0000_0040);
    chk("t2_mem_we_T", {31'd0, mem_we_w[1]}, 32'd0);
    cyc(); d_req = 1'b0; #1;
    chk("t2_wait_T1", {30'd0, if_gnt_w[1], d_rvalid_w[1]}, 32'd0);
    chk("t2_busy_T1", {31'd0, busy_w[1]}, 32'd1);
    cyc(); #1;
    chk("t2_d_rvalid_T2", {31'd0, d_rvalid_w[1]}, 32'd1);
    chk("t2_if_gnt_T2", {31'd0, if_gnt_w[1]}, 32'd1);
    chk("t2_mem_addr_T2", mem_addr_w[1], 32'h0000_0100);
    cyc(); if_req = 1'b0; #1;
    chk("t2_if_rvalid_T3", {31'd0, if_rvalid_w[1]}, 32'd0);
    chk("t2_d_rvalid_T3", {31'd0, d_rvalid_w[1]}, 32'd0);
    cyc(); #1;
    chk("t2_if_rvalid_T4", {31'd0, if_rvalid_w[1]}, 32'd1);
    cyc(); #1;
    chk("t2_busy_T5", {31'd0, busy_w[1]}, 32'd0);

    // Scenario 3: starvation limit, grant order D,D,D,IF,D,D,D,IF
    do_reset();
    d_order = 8'b0111_0111;
    if_req = 1'b1; d_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t3_d_gnt_%0d", k), {31'd0, d_gnt_w[0]}, {31'd0, d_order[k]});
      chk($sformatf("t3_if_gnt_%0d", k), {31'd0, if_gnt_w[0]}, {31'd0, ~d_order[k]});
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;

    // Scenario 4: LAT=3 fetch killed while outstanding, then kill on the response cycle
    do_reset();
    if_req = 1'b1;
    #1;
    chk("t4_if_gnt_T", {31'd0, if_gnt_w[2]}, 32'd1);
    cyc(); if_req = 1'b0; if_kill = 1'b1; #1;
    cyc(); if_kill = 1'b0; #1;
    cyc(); if_req = 1'b1; #1;
    chk("t4_no_rvalid_T3", {31'd0, if_rvalid_w[2]}, 32'd0);
    chk("t4_if_gnt_T3", {31'd0, if_gnt_w[2]}, 32'd1);
    cyc(); if_req = 1'b0; #1;
    cyc(); #1;
    cyc(); #1;
    chk("t4_rvalid_T6", {31'd0, if_rvalid_w[2]}, 32'd1);
    if_req = 1'b1; #1;
    chk("t4_if_gnt_T6", {31'd0, if_gnt_w[2]}, 32'd1);
    cyc(); if_req = 1'b0; #1;
    cyc(); #1;
    cyc(); if_kill = 1'b1; if_req = 1'b1; #1;
    chk("t4_kill_resp", {31'd0, if_rvalid_w[2]}, 32'd0);
    chk("t4_kill_blocks", {31'd0, if_gnt_w[2]}, 32'd0);
    if_kill = 1'b0; if_req = 1'b0;

    // Scenario 5: LAT=2 byte-enabled data write with fetch waiting
    do_reset();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0080;
    d_wdata = 32'h1234_5678; d_be = 4'b0011; if_req = 1'b1;
    #1;
    chk("t5_d_gnt", {31'd0, d_gnt_w[1]}, 32'd1);
    chk("t5_if_gnt", {31'd0, if_gnt_w[1]}, 32'd0);
    chk("t5_mem_en_we", {30'd0, mem_en_w[1], mem_we_w[1]}, 32'd3);
    chk("t5_mem_be", {28'd0, mem_be_w[1]}, 32'h3);
    chk("t5_mem_wdata", mem_wdata_w[1], 32'h1234_5678);
    chk("t5_mem_addr", mem_addr_w[1], 32'h0000_0080);
    cyc(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("t5_d_rvalid_T1", {31'd0, d_rvalid_w[1]}, 32'd0);
    cyc(); #1;
    chk("t5_d_rvalid_T2", {31'd0, d_rvalid_w[1]}, 32'd1);
    chk("t5_if_gnt_T2", {31'd0, if_gnt_w[1]}, 32'd1);
    chk("t5_mem_be_T2", {28'd0, mem_be_w[1]}, 32'd0);
    chk("t5_mem_we_T2", {31'd0, mem_we_w[1]}, 32'd0);
    if_req = 1'b0;

    // Scenario 6: reset in the middle of a LAT=2 read
    do_reset();
    d_req = 1'b1; d_addr = 32'h0000_0040;
    #1;
    chk("t6_d_gnt_T", {31'd0, d_gnt_w[1]}, 32'd1);
    cyc(); d_req = 1'b0; reset = 1'b1; #1;
    cyc(); reset = 1'b0; #1;
    chk("t6_d_rvalid_T2", {31'd0, d_rvalid_w[1]}, 32'd0);
    chk("t6_busy_T2", {31'd0, busy_w[1]}, 32'd0);
    chk("t6_outs_T2", {28'd0, d_gnt_w[1], if_gnt_w[1], mem_en_w[1], mem_we_w[1]}, 32'd0);
    chk("t6_mem_be_T2", {28'd0, mem_be_w[1]}, 32'd0);
    cyc(); #1;
    chk("t6_d_rvalid_T3", {31'd0, d_rvalid_w[1]}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
